// File: rtl/alu_mode_sequencer_if.sv
// alu_mode_sequencer_if: board switch inputs and sequenced ALU/display outputs
interface alu_mode_sequencer_if;
    logic [9:0] DIP_input;
    logic [5:0] PUSHSW_input;
    logic [9:0] operand;
    logic [2:0] mode;
    logic       display_en;
    logic       cmd_pulse;
    modport master (output DIP_input, PUSHSW_input, input operand, mode, display_en, cmd_pulse);
    modport slave (input DIP_input, PUSHSW_input, output operand, mode, display_en, cmd_pulse);
endinterface

// File: rtl/alu_mode_sequencer.sv
// alu_mode_sequencer: debounced push-button command front-end for the 7-op ALU with display settle gating.
// Optional AUTO_SCAN_EN: an idle dwell of SCAN_CYCLES in SHOW issues an internal NEXT command.
module alu_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 4,
    parameter int SCAN_CYCLES     = 1024
) (
    input logic clk,
    input logic rst,
    alu_mode_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic {SETTLE, SHOW} state_t;
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (SCAN_CYCLES < 1) begin : g_bad_scan
        $error("SCAN_CYCLES must be at least 1");
    end
    state_t state;
    logic [5:0] sync1, sync2, level, flip, press;
    logic [DW-1:0] db_cnt [6];
    logic [SW-1:0] settle_cnt;
    logic [9:0] operand;
    logic [2:0] mode, btn, next_mode;
    logic display_en, cmd_pulse, btn_cmd, auto_fire, cmd;
    always_comb begin
        for (int i = 0; i < 6; i++) flip[i] = sync2[i] != level[i] && db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1);
    end
    // a press is an accepted-level flip towards 1; lowest index wins
    assign press = flip & sync2;
    always_comb begin
        btn = 3'd0;
        for (int i = 5; i >= 0; i--) if (press[i]) btn = 3'(i);
    end
    assign btn_cmd = |press;
`ifdef AUTO_SCAN_EN
    localparam int CW = $clog2(SCAN_CYCLES + 1);
    logic [CW-1:0] dwell;
    assign auto_fire = state == SHOW && !btn_cmd && dwell == CW'(SCAN_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || state != SHOW || btn_cmd || auto_fire) dwell <= '0;
        else dwell <= dwell + 1'b1;
    end
`else
    assign auto_fire = 1'b0;
`endif
    assign cmd = btn_cmd | auto_fire;
    assign next_mode = (!btn_cmd || btn == 3'd5) ? (mode == 3'd6 ? 3'd0 : mode + 3'd1) : btn;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
            state <= SETTLE;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
            mode <= 3'd0;
            operand <= '0;
            display_en <= 1'b0;
            cmd_pulse <= 1'b0;
        end else begin
            sync1 <= bus.PUSHSW_input;
            sync2 <= sync1;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == level[i]) db_cnt[i] <= '0;
                else if (flip[i]) begin
                    level[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else db_cnt[i] <= db_cnt[i] + 1'b1;
            end
            cmd_pulse <= cmd;
            if (cmd) begin
                mode <= next_mode;
                operand <= bus.DIP_input;
                state <= SETTLE;
                settle_cnt <= SW'(SETTLE_CYCLES - 1);
                display_en <= 1'b0;
            end else begin
                if (mode == 3'd7) mode <= 3'd0;
                if (state == SETTLE) begin
                    if (settle_cnt == '0) begin
                        state <= SHOW;
                        display_en <= 1'b1;
                    end else settle_cnt <= settle_cnt - 1'b1;
                end
            end
        end
    end
    assign bus.operand = operand;
    assign bus.mode = mode;
    assign bus.display_en = display_en;
    assign bus.cmd_pulse = cmd_pulse;
endmodule

// File: doc/alu_mode_sequencer.md
Name: alu_mode_sequencer

Overview:
Sequencing front-end for the 7-operation ALU datapath. It debounces the six push switches and turns presses into single-cycle commands. It maintains the registered 3-bit operation select (0..6), snapshots the 10-bit DIP operand word on each accepted command, and gates the display through a short settle window so the seven-segment outputs never show a half-updated result. It sits between the board inputs and the ALU operation units plus display controller, replacing the purely combinational mode selection.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable samples required before a switch level is accepted (>=2)
SETTLE_CYCLES, 4, cycles the display stays blanked after a command (>=1)
SCAN_CYCLES, 1024, auto-scan dwell per mode (used only with AUTO_SCAN_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
DIP_input  input  10  raw operand switches; [9:5]/[9:4] and [4:0]/[3:0] fields interpreted by the ALU ops
PUSHSW_input  input  6  raw push switches, active-high (1 = pressed), asynchronous to clk
operand  output  10  latched DIP snapshot feeding all operation units
mode  output  3  registered operation select, 0..6
display_en  output  1  1 = seven-segment outputs valid; 0 = display controller must blank
cmd_pulse  output  1  one-cycle strobe on each accepted command

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: operand=0, mode=0, display_en=0, cmd_pulse=0, FSM=SETTLE with settle counter loaded, debounce state cleared (all buttons released).
- Input sync: each PUSHSW bit passes through a 2-FF synchronizer before debounce. DIP is sampled directly; it is static by use.
- Debounce: per-bit counter. The synchronized level must differ from the accepted level for DEBOUNCE_CYCLES consecutive cycles before the accepted level flips. Any mismatch-free cycle resets the counter.
- Press event: a 0->1 transition of an accepted level. Releases generate nothing.
- Simultaneous presses in the same cycle: the lowest index wins and the others are discarded. A button still held does not re-fire.
- Command decode:
  - Button k (k=0..4) sets mode=k.
  - Button 5 is NEXT: mode = (mode==6) ? 0 : mode+1.
- On each accepted command, in the same edge: mode updates, operand <= DIP_input, cmd_pulse=1 for exactly one cycle, FSM -> SETTLE.
- Latency: raw press stable -> cmd_pulse = 2 (sync) + DEBOUNCE_CYCLES cycles.
- FSM states:
  - SETTLE: display_en=0; counter counts SETTLE_CYCLES down; at 0 -> SHOW.
  - SHOW: display_en=1; holds until the next command.
  - A command arriving during SETTLE reloads the counter and remains in SETTLE.
- mode never leaves 0..6. Value 7 is unreachable; if it is ever seen it is forced to 0 on the next edge.
- operand changes only on a command. DIP movement alone in SHOW does not alter outputs.
- rst mid-settle or mid-debounce: everything returns to reset values the next edge. A held button is seen as a new press once its debounce completes after reset.

Optional Feature:
AUTO_SCAN_EN:
- Defined: in SHOW with no command for SCAN_CYCLES consecutive cycles, an internal NEXT command fires. It behaves identically to button 5, including operand snapshot, cmd_pulse and SETTLE. Any real command restarts the dwell counter.
- Undefined: no dwell counter is built and mode changes only on button commands.

Test Plan:
- Reset: rst high for 3 cycles, release -> mode=0, operand=0, cmd_pulse=0; display_en=0 for 4 cycles then 1.
- Debounce: DIP=10'h2A5; PUSHSW[2] toggles every 5 cycles for 40 cycles, then held -> no cmd_pulse during bounce; exactly one pulse 18 cycles after stable high; mode=2, operand=10'h2A5.
- Priority and hold: PUSHSW=6'b001100 asserted together and held 200 cycles -> a single cmd_pulse, mode=2; no further pulses until release and re-press.
- NEXT wrap: starting at mode=5, press button 5 twice, then once more -> mode 6, then 0, then 1; each press gives one cmd_pulse and a 4-cycle display_en=0 window.
- Settle retrigger: second command arriving 2 cycles after the first -> display_en stays 0 until 4 cycles after the second cmd_pulse.
- AUTO_SCAN_EN with SCAN_CYCLES=8: idle in SHOW at mode=6 -> after 8 cycles internal NEXT gives mode=0 with a cmd_pulse; a button press at cycle 5 restarts the dwell.
